pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and fetch-control stage of the single-cycle RV32I core; sits directly upstream of the instruction memory.
- Drives the byte address into instruction memory and receives the combinational instruction word back.
- Selects the next PC (sequential, branch, JALR), handles stall, and halts on ECALL/EBREAK.
- Traps on misaligned control-flow targets and presents a qualified instruction to decode.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- XLEN, 32, PC and instruction width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; 0 = stall, PC held
- pc_src  in  2  next-PC select: 0 = PC+4, 1 = branch_target, 2 = jalr_target, 3 = reserved (treated as 0)
- branch_target  in  32  byte address from the branch/JAL adder
- jalr_target  in  32  rs1+imm from the ALU
- imem_instr  in  32  instruction word returned by instruction memory for imem_addr
- imem_addr  out  32  current PC, driven to instruction memory
- pc_plus4  out  32  PC+4, for JAL/JALR link
- instr  out  32  imem_instr when valid, else 32'h0000_0013 (NOP)
- valid  out  1  instruction on instr is architecturally live this cycle
- halted  out  1  core halted by ECALL/EBREAK
- trap  out  1  misaligned-target trap taken
- trap_addr  out  32  offending target address; 0 when trap=0

Behaviour:
- State machine (fetch_state_e): BOOT, RUN, HALT, TRAP.
- Reset (async, rst_n=0):
  - state=BOOT, PC=RESET_VECTOR.
  - valid=0, halted=0, trap=0, trap_addr=0, instr=NOP.
- BOOT: one cycle with valid=0 (instruction memory settles), then unconditional transition to RUN; PC unchanged.
- RUN:
  - valid=en.
  - Combinational next-PC candidate per pc_src. JALR candidate = jalr_target & ~32'h1.
  - Misaligned = candidate[1:0] != 0 (branch); candidate[1] != 0 (JALR after bit-0 clear).
- Edge priority in RUN when en=1, highest first:
  1. imem_instr == 32'h0000_0073 or 32'h0010_0073 → HALT; PC holds at the ECALL/EBREAK address; pc_src ignored.
  2. Misaligned candidate → TRAP; trap_addr ← candidate; PC holds.
  3. Otherwise PC ← candidate.
- RUN with en=0: PC and state hold; halt/trap detection suppressed; valid=0.
- HALT: valid=0, halted=1, PC frozen; only reset exits.
- TRAP: valid=0, trap=1, trap_addr stable, PC frozen; only reset exits.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no trap.
- Outputs imem_addr, pc_plus4 and valid/instr are combinational from registered state and inputs within the same cycle (zero latency). PC update takes effect one clock after the select.
- Reset asserted mid-operation overrides every state immediately; the first post-reset edge with rst_n=1 leaves BOOT.

Optional Feature:
- FETCH_COUNTER_EN defined: adds output fetch_count [31:0].
  - Reset 0.
  - Increments on every edge where state=RUN and en=1, including the halting instruction.
  - Wraps modulo 2^32.
  - Holds in HALT/TRAP.
- Not defined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - typedef enum logic [1:0] pc_src_e (PC_SEQ, PC_BRANCH, PC_JALR)
  - typedef enum logic [1:0] fetch_state_e
  - constants INSTR_ECALL, INSTR_EBREAK, INSTR_NOP
- One sub-module, pc_next_sel: combinational candidate selection plus misalignment check, producing next_pc and misaligned. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release: rst_n low 2 cycles then high → cycle 0 valid=0, imem_addr=0; cycle 1 valid=1, instr=0x00500093 (ADDI x1,x0,5).
- Sequential fetch, pc_src=0, en=1: imem_addr steps 0x0, 0x4, 0x8, 0xC; pc_plus4 = imem_addr+4 each cycle.
- Stall: en=0 for 3 cycles at PC=0x8 → imem_addr stays 0x8, valid=0; en=1 → next edge PC=0xC.
- Redirects:
  - pc_src=1, branch_target=0x20 → next PC 0x20, instr=0x0020a333.
  - pc_src=2, jalr_target=0x11 → PC=0x10.
- Misaligned: pc_src=1, branch_target=0x06 → trap=1, trap_addr=0x6, PC frozen, valid=0 until reset.
- Halt, with FETCH_COUNTER_EN: imem_instr=0x00000073 at PC=0x14 (forced in the bench) → halted=1, PC stays 0x14, fetch_count frozen at 6; pulsing rst_n returns to BOOT with fetch_count=0.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Imported by pc_next_sel and pc_fetch_unit.
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JALR   = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_TRAP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

   function automatic logic is_halt_instr(input logic [31:0] i);
      return (i == INSTR_ECALL) || (i == INSTR_EBREAK);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC candidate mux and misalignment check.
// Pure combinational; reserved select falls back to PC+4.
module pc_next_sel
   import riscv_fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   // Select candidate; JALR drops bit 0, so only bit 1 can misalign it
   always_comb begin
      pc_plus4 = pc + XLEN'(4);
      next_pc  = pc_plus4;
      case (pc_src_e'(pc_src))
         PC_BRANCH: next_pc = branch_target;
         PC_JALR:   next_pc = jalr_target & ~XLEN'(1);
         default:   next_pc = pc_plus4;
      endcase
      misaligned = (next_pc[1:0] != 2'b00);
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM (BOOT/RUN/HALT/TRAP) for the RV32I core.
// Optional FETCH_COUNTER_EN adds the fetch_count output.
module pc_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic [XLEN-1:0] imem_instr,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] instr,
   output logic            valid,
   output logic            halted,
   output logic            trap,
   output logic [XLEN-1:0] trap_addr
`ifdef FETCH_COUNTER_EN
   ,
   output logic [31:0]     fetch_count
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            trap_q, trap_d;
   logic [XLEN-1:0] trap_addr_q, trap_addr_d;
   logic [XLEN-1:0] next_pc;
   logic            misaligned;
   logic            fire;

   pc_next_sel #(
      .XLEN(XLEN)
   ) u_sel (
      .pc           (pc_q),
      .pc_src       (pc_src),
      .branch_target(branch_target),
      .jalr_target  (jalr_target),
      .pc_plus4     (pc_plus4),
      .next_pc      (next_pc),
      .misaligned   (misaligned)
   );

   assign fire = (state_q == ST_RUN) && en;

   // Fetch outputs are live in the same cycle as the registered PC
   always_comb begin
      imem_addr = pc_q;
      valid     = fire;
      instr     = fire ? imem_instr : INSTR_NOP;
      halted    = halted_q;
      trap      = trap_q;
      trap_addr = trap_addr_q;
   end

   // Next-state: halt beats misalign trap beats PC update
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halted_d    = halted_q;
      trap_d      = trap_q;
      trap_addr_d = trap_addr_q;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (en) begin
               if (is_halt_instr(imem_instr)) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else if (misaligned) begin
                  state_d     = ST_TRAP;
                  trap_d      = 1'b1;
                  trap_addr_d = next_pc;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         ST_TRAP: state_d = ST_TRAP;
      endcase
   end

   // State and PC registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_VECTOR;
         halted_q    <= 1'b0;
         trap_q      <= 1'b0;
         trap_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         halted_q    <= halted_d;
         trap_q      <= trap_d;
         trap_addr_q <= trap_addr_d;
      end
   end

`ifdef FETCH_COUNTER_EN
   logic [31:0] cnt_q, cnt_d;

   // Count every enabled RUN edge, halting instruction included
   always_comb begin
      cnt_d = fire ? cnt_q + 32'd1 : cnt_q;
   end

   // Fetch counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign fetch_count = cnt_q;
`endif

endmodule
